oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 150 +++++++++++++++
 tb/tb_oam_dma.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma: sprite-attribute (OAM) DMA engine.
//
// A CPU write to TRIGGER_ADDR latches the written byte as the source page and
// copies XFER_LEN bytes from {src_hi, 8'h00} upward to DEST_BASE upward, one
// byte every CYCLES_PER_BYTE clocks, after a one-byte-time start-up delay.
// Pages E0..FF are folded down by 0x20 (echo RAM).
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   rst_n       asynchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   cpu_wen     CPU bus write strobe
//   cpu_addr    CPU bus address
//   cpu_wdata   CPU bus write data
//   dma_reg     last value written to TRIGGER_ADDR (register readback)
//   dma_active  memory bus owned by this block (bus mux select)
//   dma_done    one-cycle pulse after the final byte has been written
//   mem_r_addr  memory read address (zero while not transferring)
//   mem_r_data  memory read data, combinational from mem_r_addr
//   mem_wen     memory write strobe, committed at the next rising edge
//   mem_w_addr  memory write address (zero while not transferring)
//   mem_w_data  memory write data (read data passed straight through)
// -----------------------------------------------------------------------------
package oam_dma_pkg;
  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
  typedef enum logic [1:0] {IDLE, START, XFER} state_t;
endpackage

module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned XFER_LEN        = 160,
  parameter addr_t       TRIGGER_ADDR    = 16'hFF46,
  parameter addr_t       DEST_BASE       = 16'hFE00
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  cpu_wen,
  input  addr_t cpu_addr,
  input  data_t cpu_wdata,
  output data_t dma_reg,
  output logic  dma_active,
  output logic  dma_done,
  output addr_t mem_r_addr,
  input  data_t mem_r_data,
  output logic  mem_wen,
  output addr_t mem_w_addr,
  output data_t mem_w_data
);

  localparam int unsigned     DIV_W    = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CYCLES_PER_BYTE - 1);
  localparam data_t           IDX_LAST = data_t'(XFER_LEN - 1);

  state_t           state, state_next;
  logic [DIV_W-1:0] div, div_next;
  data_t            idx, idx_next;
  logic             active_next;
  logic             done_next;
  logic             trigger;
  data_t            src_hi;

  assign trigger = cpu_wen && (cpu_addr == TRIGGER_ADDR);

  // Echo RAM at E000-FDFF mirrors C000-DDFF.
  assign src_hi = (dma_reg < 8'hE0) ? dma_reg : dma_reg - 8'h20;

  // NOTE: every output of this block is given a default before the case so
  // that no path leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_next  = state;
    div_next    = div;
    idx_next    = idx;
    active_next = dma_active;
    done_next   = 1'b0;
    mem_wen     = 1'b0;
    mem_r_addr  = 16'h0000;
    mem_w_addr  = 16'h0000;
    mem_w_data  = 8'h00;

    unique case (state)
      IDLE: ;
      START: begin
        if (div == DIV_LAST) begin
          state_next  = XFER;
          div_next    = '0;
          idx_next    = '0;
          active_next = 1'b1;
        end else begin
          div_next = div + DIV_W'(1);
        end
      end
      XFER: begin
        mem_r_addr = {src_hi, idx};
        mem_w_addr = DEST_BASE + addr_t'(idx);
        mem_w_data = mem_r_data;
        if (div == DIV_LAST) begin
          mem_wen  = 1'b1;
          div_next = '0;
          if (idx == IDX_LAST) begin
            state_next  = IDLE;
            idx_next    = '0;
            active_next = 1'b0;
            done_next   = 1'b1;
          end else begin
            idx_next = idx + 8'd1;
          end
        end else begin
          div_next = div + DIV_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // A new trigger wins over everything: it kills the pending strobe and any
    // completion pulse, and restarts. The bus lock is kept as it was, so a
    // restart out of XFER never hands the bus back to the CPU mid-copy.
    if (trigger) begin
      state_next  = START;
      div_next    = '0;
      idx_next    = '0;
      active_next = dma_active;
      done_next   = 1'b0;
      mem_wen     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      div        <= '0;
      idx        <= '0;
      dma_reg    <= 8'h00;
      dma_active <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      state      <= state_next;
      div        <= div_next;
      idx        <= idx_next;
      dma_active <= active_next;
      dma_done   <= done_next;
      if (trigger) dma_reg <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma: self-checking bench for oam_dma.
// dut  : default parameters (4 clocks per byte, 160 bytes).
// dut2 : CYCLES_PER_BYTE = 2, own bus and memory.
// Expected OAM contents come from per-test copies of the source bytes, and
// expected timing from (XFER_LEN+1)*CYCLES_PER_BYTE and the echo-fold rule.
// -----------------------------------------------------------------------------
module tb_oam_dma;
  import oam_dma_pkg::*;

  localparam int LEN = 160;

  logic  clk = 1'b0;
  logic  rst_n = 1'b1;

  logic  cpu_wen;
  addr_t cpu_addr;
  data_t cpu_wdata;
  data_t dma_reg;
  logic  dma_active, dma_done, mem_wen;
  addr_t mem_r_addr, mem_w_addr;
  data_t mem_r_data, mem_w_data;

  logic  cpu2_wen;
  addr_t cpu2_addr;
  data_t cpu2_wdata;
  data_t dma_reg2;
  logic  dma_active2, dma_done2, mem_wen2;
  addr_t mem_r_addr2, mem_w_addr2;
  data_t mem_r_data2, mem_w_data2;

  data_t mem  [65536];
  data_t mem2 [65536];
  assign mem_r_data  = mem[mem_r_addr];
  assign mem_r_data2 = mem2[mem_r_addr2];

  oam_dma dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_reg(dma_reg), .dma_active(dma_active), .dma_done(dma_done),
    .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_wen(mem_wen), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data)
  );

  oam_dma #(.CYCLES_PER_BYTE(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cpu_wen(cpu2_wen), .cpu_addr(cpu2_addr), .cpu_wdata(cpu2_wdata),
    .dma_reg(dma_reg2), .dma_active(dma_active2), .dma_done(dma_done2),
    .mem_r_addr(mem_r_addr2), .mem_r_data(mem_r_data2),
    .mem_wen(mem_wen2), .mem_w_addr(mem_w_addr2), .mem_w_data(mem_w_data2)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int edge_cnt = 0, trig_edge = 0, wr_cnt = 0, last_wr_edge = 0;
  int done_cnt = 0, done_edge = 0, act_cnt = 0;
  int trig2_edge = 0, wr2_cnt = 0, last_wr2_edge = 0, done2_cnt = 0;

  data_t model_a [LEN];
  data_t model_b [LEN];
  data_t oam_snap [LEN];

  // Bus monitor: sees pre-edge values, commits memory writes, logs events.
  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    if (cpu_wen && cpu_addr == 16'hFF46) trig_edge = edge_cnt;
    if (mem_wen) begin
      mem[mem_w_addr] = mem_w_data;
      wr_cnt       = wr_cnt + 1;
      last_wr_edge = edge_cnt;
    end
    if (dma_done) begin
      done_cnt  = done_cnt + 1;
      done_edge = edge_cnt;
    end
    if (dma_active) act_cnt = act_cnt + 1;
    if (cpu2_wen && cpu2_addr == 16'hFF46) trig2_edge = edge_cnt;
    if (mem_wen2) begin
      mem2[mem_w_addr2] = mem_w_data2;
      wr2_cnt       = wr2_cnt + 1;
      last_wr2_edge = edge_cnt;
    end
    if (dma_done2) done2_cnt = done2_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic data_t ref_src_hi(input data_t v);
    return (v >= 8'hE0) ? data_t'(v - 8'h20) : v;
  endfunction

  task automatic clear_stats();
    wr_cnt = 0; done_cnt = 0; act_cnt = 0; done_edge = 0; last_wr_edge = 0;
  endtask

  // Random source page; OAM preloaded with the complement so unwritten bytes show.
  task automatic fill_src(input data_t hi, input bit pat, input bit sel);
    for (int i = 0; i < LEN; i++) begin
      data_t d;
      d = pat ? data_t'(i) ^ 8'h5A : data_t'($urandom);
      mem[{hi, data_t'(i)}] = d;
      if (sel) model_b[i] = d; else model_a[i] = d;
      mem[16'hFE00 + 16'(i)] = ~d;
    end
  endtask

  function automatic int oam_mismatch(input int lo, input int hi, input bit sel);
    int n = 0;
    for (int i = lo; i < hi; i++)
      if (mem[16'hFE00 + 16'(i)] !== (sel ? model_b[i] : model_a[i])) n++;
    return n;
  endfunction

  task automatic cpu_write(input addr_t a, input data_t d);
    @(negedge clk);
    cpu_wen = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic cpu2_write(input addr_t a, input data_t d);
    @(negedge clk);
    cpu2_wen = 1'b1; cpu2_addr = a; cpu2_wdata = d;
    @(posedge clk); #1;
    cpu2_wen = 1'b0; cpu2_addr = '0; cpu2_wdata = '0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start;
    start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (done_cnt != start) ok = 1'b1;
    end
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = (wr_cnt >= n);
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (wr_cnt >= n) ok = 1'b1;
    end
  endtask

  // One complete transfer with start-up, in-flight and completion checks.
  task automatic run_xfer(input data_t v, input data_t hi, input bit pat);
    int e0;
    bit ok;
    clear_stats();
    fill_src(hi, pat, 1'b0);
    cpu_write(16'hFF46, v);
    e0 = trig_edge;
    @(negedge clk);
    check("start_wen",   32'(mem_wen), 0);
    check("start_raddr", 32'(mem_r_addr), 0);
    check("start_waddr", 32'(mem_w_addr), 0);
    check("start_active_unlocked", 32'(dma_active), 0);
    check("dma_reg_readback", 32'(dma_reg), 32'(v));
    repeat (5) @(negedge clk);
    check("xfer_raddr_byte0", 32'(mem_r_addr), 32'({hi, 8'h00}));
    check("xfer_waddr_byte0", 32'(mem_w_addr), 32'h0000_FE00);
    check("xfer_active", 32'(dma_active), 1);
    cpu_write(16'hFF45, data_t'($urandom));
    cpu_write(16'hFF47, data_t'($urandom));
    wait_done(900, ok);
    check("done_seen", 32'(ok), 1);
    check("write_count", 32'(wr_cnt), LEN);
    check("latency", 32'(last_wr_edge - e0), (LEN + 1) * 4);
    check("done_count", 32'(done_cnt), 1);
    check("done_after_last_write", 32'(done_edge), 32'(last_wr_edge + 1));
    check("done_single_cycle", 32'(dma_done), 0);
    check("active_cycles", 32'(act_cnt), LEN * 4);
    check("oam_contents", 32'(oam_mismatch(0, LEN, 1'b0)), 0);
    check("dma_reg_after_noise", 32'(dma_reg), 32'(v));
  endtask

  // Transfer v1, then retrigger with v2 exactly in the strobe cycle of byte n.
  task automatic abort_test(input data_t v1, input data_t h1, input data_t v2,
                            input data_t h2, input int n);
    int e0, e1;
    bit ok;
    clear_stats();
    fill_src(h1, 1'b0, 1'b0);
    fill_src(h2, 1'b0, 1'b1);
    cpu_write(16'hFF46, v1);
    e0 = trig_edge;
    wait_writes(n, 900, ok);
    check("abort_reached_byte", 32'(ok), 1);
    check("abort_old_bytes", 32'(oam_mismatch(0, n, 1'b0)), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    cpu_wen = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = v2;
    #1;
    check("abort_strobe_suppressed", 32'(mem_wen), 0);
    @(posedge clk); #1;
    cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    e1 = trig_edge;
    check("abort_no_write_at_trigger", 32'(wr_cnt), 32'(n));
    check("abort_no_done", 32'(dma_done), 0);
    check("abort_bus_locked", 32'(dma_active), 1);
    wait_done(900, ok);
    check("abort_done_seen", 32'(ok), 1);
    check("abort_done_count", 32'(done_cnt), 1);
    check("abort_write_count", 32'(wr_cnt), 32'(n + LEN));
    check("abort_latency", 32'(last_wr_edge - e1), (LEN + 1) * 4);
    check("abort_active_cycles", 32'(act_cnt), 32'(e1 - e0 + LEN * 4));
    check("abort_new_contents", 32'(oam_mismatch(0, LEN, 1'b1)), 0);
    check("abort_dma_reg", 32'(dma_reg), 32'(v2));
  endtask

  typedef struct {
    data_t val;
    data_t exp_hi;
    bit    pat;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int e0, t2, mism;
    bit ok;
    data_t v;

    vecs = '{'{8'hC1, 8'hC1, 1'b1},
             '{8'hE3, 8'hC3, 1'b0},
             '{8'hDF, 8'hDF, 1'b0},
             '{8'hE0, 8'hC0, 1'b0},
             '{8'hFF, 8'hDF, 1'b0}};

    cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
    cpu2_wen = 0; cpu2_addr = '0; cpu2_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      mem2[i] = 8'h00;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_dma_reg", 32'(dma_reg), 0);
    check("rst_active",  32'(dma_active), 0);
    check("rst_done",    32'(dma_done), 0);
    check("rst_wen",     32'(mem_wen), 0);
    check("rst_raddr",   32'(mem_r_addr), 0);
    check("rst_waddr",   32'(mem_w_addr), 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven transfers, including the echo-fold boundary E0 / DF.
    for (int k = 0; k < 5; k++) run_xfer(vecs[k].val, vecs[k].exp_hi, vecs[k].pat);

    // Retrigger with the value already in dma_reg still starts a transfer.
    run_xfer(8'hFF, 8'hDF, 1'b0);

    // Randomized trigger values against the fold rule.
    for (int r = 0; r < 3; r++) begin
      v = data_t'($urandom_range(0, 255));
      run_xfer(v, ref_src_hi(v), 1'b0);
    end

    // Restart mid-transfer, and restart coincident with the final strobe.
    abort_test(8'hC1, 8'hC1, 8'hD0, 8'hD0, 50);
    abort_test(8'hE5, 8'hC5, 8'h42, 8'h42, LEN - 1);

    // Reset during byte 80.
    clear_stats();
    fill_src(8'hC1, 1'b0, 1'b0);
    for (int i = 0; i < LEN; i++) oam_snap[i] = mem[16'hFE00 + 16'(i)];
    cpu_write(16'hFF46, 8'hC1);
    wait_writes(80, 900, ok);
    check("rst_reached_byte80", 32'(ok), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid_wen",    32'(mem_wen), 0);
    check("rst_mid_active", 32'(dma_active), 0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_more_writes", 32'(wr_cnt), 80);
    check("rst_no_resume",      32'(dma_active), 0);
    check("rst_idle_raddr",     32'(mem_r_addr), 0);
    check("rst_dma_reg_clear",  32'(dma_reg), 0);
    check("rst_head_written",   32'(oam_mismatch(0, 80, 1'b0)), 0);
    mism = 0;
    for (int i = 80; i < LEN; i++)
      if (mem[16'hFE00 + 16'(i)] !== oam_snap[i]) mism++;
    check("rst_tail_untouched", 32'(mism), 0);

    // Trigger accepted on the first edge after reset release.
    clear_stats();
    fill_src(8'h7B, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    cpu_wen = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = 8'h7B;
    @(posedge clk); #1;
    cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    e0 = trig_edge;
    wait_done(900, ok);
    check("post_rst_done_seen", 32'(ok), 1);
    check("post_rst_latency", 32'(last_wr_edge - e0), (LEN + 1) * 4);
    check("post_rst_contents", 32'(oam_mismatch(0, LEN, 1'b1)), 0);

    // Two clocks per byte, with neighbouring addresses written around the trigger.
    for (int i = 0; i < LEN; i++) begin
      v = data_t'($urandom);
      mem2[{8'hC2, data_t'(i)}] = v;
      model_a[i] = v;
      mem2[16'hFE00 + 16'(i)] = ~v;
    end
    cpu2_write(16'hFF45, 8'h11);
    repeat (4) @(negedge clk);
    check("cpb2_ff45_ignored_reg", 32'(dma_reg2), 0);
    check("cpb2_ff45_no_write", 32'(wr2_cnt), 0);
    cpu2_write(16'hFF45, 8'h22);
    cpu2_write(16'hFF46, 8'hC2);
    t2 = trig2_edge;
    cpu2_write(16'hFF47, 8'h33);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk); #1;
      if (done2_cnt != 0) ok = 1'b1;
    end
    check("cpb2_done_seen", 32'(ok), 1);
    check("cpb2_latency", 32'(last_wr2_edge - t2), (LEN + 1) * 2);
    check("cpb2_write_count", 32'(wr2_cnt), LEN);
    check("cpb2_dma_reg", 32'(dma_reg2), 32'h0000_00C2);
    mism = 0;
    for (int i = 0; i < LEN; i++)
      if (mem2[16'hFE00 + 16'(i)] !== model_a[i]) mism++;
    check("cpb2_contents", 32'(mism), 0);
    repeat (20) @(negedge clk);
    check("cpb2_single_done", 32'(done2_cnt), 1);
    check("cpb2_idle_after", 32'(dma_active2), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
